// File: rtl/wbutxuart.sv
// 8N1 serial transmitter for the debugging bus output chain, fixed baud divider.
// Optional flow control: define WBUTXUART_CTS_EN to gate new frames on i_cts_n.
`timescale 1ns/1ps
module wbutxuart #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_stb,
    input  logic [7:0] i_data,
    input  logic       i_cts_n,
    output logic       o_busy,
    output logic       o_uart_tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [23:0] baudCnt_q, baudCnt_d;
    logic [3:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ctsHold;
    logic        accept;
    logic        bitEnd;

`ifdef WBUTXUART_CTS_EN
    logic ctsMeta_q, ctsSync_q;

    // Both flops reset high so nothing starts until the far end is confirmed ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctsMeta_q <= 1'b1;
            ctsSync_q <= 1'b1;
        end else begin
            ctsMeta_q <= i_cts_n;
            ctsSync_q <= ctsMeta_q;
        end
    end

    assign ctsHold = ctsSync_q;
`else
    logic unused_cts;
    assign unused_cts = i_cts_n;
    assign ctsHold    = 1'b0;
`endif

    assign o_busy    = busy_q | ctsHold;
    assign o_uart_tx = tx_q;
    assign accept    = i_stb && !o_busy;
    assign bitEnd    = (baudCnt_q == 24'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            baudCnt_q <= 24'd0;
            bitIdx_q  <= 4'd0;
            shift_q   <= 8'hFF;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baudCnt_d = bitEnd ? baudCnt_q : baudCnt_q - 24'd1;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (bitEnd) begin
                    state_d   = DATA;
                    baudCnt_d = CLOCKS_PER_BAUD - 24'd1;
                    bitIdx_d  = 4'd1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCnt_d = CLOCKS_PER_BAUD - 24'd1;
                    bitIdx_d  = bitIdx_q + 4'd1;
                    if (bitIdx_q == 4'd8) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                // Drop busy one cycle early so the last stop cycle can accept the next byte.
                if (baudCnt_q == 24'd1) begin
                    busy_d = 1'b0;
                end
                if (bitEnd) begin
                    state_d  = IDLE;
                    bitIdx_d = 4'd0;
                    tx_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (accept && (state_q == IDLE || (state_q == STOP && bitEnd))) begin
            state_d   = START;
            baudCnt_d = CLOCKS_PER_BAUD - 24'd1;
            bitIdx_d  = 4'd0;
            shift_d   = i_data;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

endmodule

// File: tb/tb_wbutxuart.sv
// Directed self-checking bench for wbutxuart: frame shape, back-to-back, hold, reset, CPB=2.
// Define WBUTXUART_CTS_EN for both files to also exercise the clear-to-send gating.
`timescale 1ns/1ps
module tb_wbutxuart;

`ifdef WBUTXUART_CTS_EN
    localparam logic BUSY_IN_RESET = 1'b1;
`else
    localparam logic BUSY_IN_RESET = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, stb, cts_n, busy, tx;
    logic [7:0] data;
    logic       stb2, busy2, tx2;
    logic [7:0] data2;

    int   checks = 0;
    int   failures = 0;
    logic txs [0:127];
    logic bs  [0:127];
    int   accCount;
    int   accAt [0:3];
    int   lows;
    int   highs;
    bit   sel;

    always #5 clk = ~clk;

    wbutxuart #(.CLOCKS_PER_BAUD(24'd4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_data(data),
        .i_cts_n(cts_n), .o_busy(busy), .o_uart_tx(tx)
    );

    wbutxuart #(.CLOCKS_PER_BAUD(24'd2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb2), .i_data(data2),
        .i_cts_n(1'b0), .o_busy(busy2), .o_uart_tx(tx2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit which, input logic v, input logic [7:0] d);
        if (which) begin
            stb2  = v;
            data2 = d;
        end else begin
            stb   = v;
            data  = d;
        end
    endtask

    // Records line and busy for cycle c, notes any acceptance, then advances one clock.
    task automatic sampleCycle(input int c);
        logic b, t, s;
        b = sel ? busy2 : busy;
        t = sel ? tx2 : tx;
        s = sel ? stb2 : stb;
        txs[c] = t;
        bs[c]  = b;
        if (s && !b) begin
            if (accCount < 4) accAt[accCount] = c;
            accCount++;
        end
        tick;
    endtask

    task automatic waitIdle(input bit which);
        int n;
        n = 0;
        while ((which ? busy2 : busy) && n < 200) begin
            tick;
            n++;
        end
        checkOutput("idleTimeout", (n >= 200), 0);
    endtask

    function automatic logic [9:0] frameBits(input int base, input int cpb);
        logic [9:0] v;
        for (int n = 0; n < 10; n++) v[9-n] = txs[base + cpb*n];
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        cts_n = 1'b0;
        sel   = 1'b0;
        applyStimulus(0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 8'h00);
        tick;
        tick;
        checkOutput("rstTx", tx, 1);
        checkOutput("rstBusy", busy, BUSY_IN_RESET);
        checkOutput("rstTx2", tx2, 1);
        rst_n = 1'b1;
        repeat (3) tick;

        // Single byte 8'hA5
        waitIdle(0);
        accCount = 0;
        applyStimulus(0, 1'b1, 8'hA5);
        for (int c = 0; c < 45; c++) begin
            sampleCycle(c);
            if (c == 0) applyStimulus(0, 1'b0, 8'h00);
        end
        checkOutput("a5Accepts", accCount, 1);
        checkOutput("a5Bits", frameBits(2, 4), 10'b0101001011);
        checkOutput("a5StartFirst", txs[1], 0);
        checkOutput("a5StartLast", txs[4], 0);
        checkOutput("a5Bit0First", txs[5], 1);
        checkOutput("a5BusyT1", bs[1], 1);
        checkOutput("a5BusyT39", bs[39], 1);
        checkOutput("a5BusyT40", bs[40], 0);
        checkOutput("a5IdleLine", txs[41], 1);
        highs = 0;
        for (int c = 1; c < 45; c++) if (bs[c]) highs++;
        checkOutput("a5BusyLen", highs, 39);

        // Back-to-back 8'h00 then 8'hFF with strobe held
        waitIdle(0);
        accCount = 0;
        applyStimulus(0, 1'b1, 8'h00);
        for (int c = 0; c < 80; c++) begin
            sampleCycle(c);
            if (c == 0) applyStimulus(0, 1'b1, 8'hFF);
        end
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("b2bAccepts", accCount, 2);
        checkOutput("b2bSecondAt", accAt[1], 40);
        checkOutput("b2bFrame1", frameBits(2, 4), 10'b0000000001);
        checkOutput("b2bFrame2", frameBits(42, 4), 10'b0111111111);
        checkOutput("b2bLastStop", txs[40], 1);
        checkOutput("b2bNoGap", txs[41], 0);

        // Hold while busy: 8'hC3 in flight, 8'h3C waiting from T+5
        waitIdle(0);
        accCount = 0;
        applyStimulus(0, 1'b1, 8'hC3);
        for (int c = 0; c < 90; c++) begin
            if (c >= 1 && c < 5)
                applyStimulus(0, 1'b0, 8'hF0 | 8'(c));
            else if (c >= 5 && accCount < 2)
                applyStimulus(0, 1'b1, 8'h3C);
            else if (c >= 5)
                applyStimulus(0, 1'b0, 8'h00);
            sampleCycle(c);
        end
        checkOutput("holdAccepts", accCount, 2);
        checkOutput("holdSecondAt", accAt[1], 40);
        checkOutput("holdFrame1", frameBits(2, 4), 10'b0110000111);
        checkOutput("holdFrame2", frameBits(42, 4), 10'b0001111001);

        // Reset during data bit 3 of 8'hF7 (only bit 3 is low)
        waitIdle(0);
        accCount = 0;
        applyStimulus(0, 1'b1, 8'hF7);
        for (int c = 0; c < 18; c++) begin
            sampleCycle(c);
            if (c == 0) applyStimulus(0, 1'b0, 8'h00);
        end
        checkOutput("midBit3", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstTx", tx, 1);
        checkOutput("asyncRstBusy", busy, BUSY_IN_RESET);
        tick;
        tick;
        rst_n = 1'b1;
        repeat (4) tick;
        checkOutput("noResumeTx", tx, 1);
        checkOutput("noResumeBusy", busy, 0);
        accCount = 0;
        applyStimulus(0, 1'b1, 8'h5A);
        for (int c = 0; c < 45; c++) begin
            sampleCycle(c);
            if (c == 0) applyStimulus(0, 1'b0, 8'h00);
        end
        checkOutput("postRstAccepts", accCount, 1);
        checkOutput("postRstFrame", frameBits(2, 4), 10'b0010110101);

        // Minimum divider, 8'h81 on the CPB=2 instance
        sel = 1'b1;
        waitIdle(1);
        accCount = 0;
        applyStimulus(1, 1'b1, 8'h81);
        for (int c = 0; c < 25; c++) begin
            sampleCycle(c);
            if (c == 0) applyStimulus(1, 1'b0, 8'h00);
        end
        checkOutput("minAccepts", accCount, 1);
        checkOutput("minBits", frameBits(2, 2), 10'b0100000011);
        checkOutput("minStart", txs[1], 0);
        checkOutput("minBusyT19", bs[19], 1);
        checkOutput("minBusyT20", bs[20], 0);
        highs = 0;
        for (int c = 1; c < 25; c++) if (bs[c]) highs++;
        checkOutput("minBusyLen", highs, 19);
        sel = 1'b0;

`ifdef WBUTXUART_CTS_EN
        // Clear-to-send gating
        waitIdle(0);
        cts_n = 1'b1;
        repeat (3) tick;
        lows = 0;
        accCount = 0;
        applyStimulus(0, 1'b1, 8'hA5);
        for (int c = 0; c < 100; c++) begin
            if (!tx) lows++;
            if (stb && !busy) accCount++;
            tick;
        end
        checkOutput("ctsNoStart", lows, 0);
        checkOutput("ctsNoAccept", accCount, 0);
        cts_n = 1'b0;
        accCount = 0;
        for (int c = 0; c < 45; c++) begin
            sampleCycle(c);
            if (accCount > 0) applyStimulus(0, 1'b0, 8'h00);
            if (c == 10) cts_n = 1'b1;
        end
        checkOutput("ctsAcceptAt", accAt[0], 2);
        checkOutput("ctsLineBefore", txs[2], 1);
        checkOutput("ctsStartAt", txs[3], 0);
        checkOutput("ctsFrame", frameBits(4, 4), 10'b0101001011);
        cts_n = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wbutxuart.md
# wbutxuart

Serial transmit back end for the debugging bus. Consumes the byte stream that the bus output chain emits (`o_stb`/`o_char` with `i_tx_busy` back-pressure) and drives an 8N1 asynchronous serial line at a fixed, parameterised baud rate. Its `o_busy` output connects directly to the output chain's `i_tx_busy` input.

## Interface
- `CLOCKS_PER_BAUD`, default 24'd868: clock cycles per serial bit; legal range 2 to 2^24-1.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stb`  in  1  byte-valid strobe from the output chain.
- `i_data`  in  8  byte to transmit; sampled only on acceptance.
- `i_cts_n`  in  1  clear-to-send, active low; used only when `WBUTXUART_CTS_EN` is defined.
- `o_busy`  out  1  transmitter cannot accept; wire to the upstream `i_tx_busy`.
- `o_uart_tx`  out  1  serial line; idle high.

## Operation
- Acceptance occurs on the cycle where `i_stb && !o_busy`. On acceptance, `i_data` is latched into the shift register.
- State machine:
  - **IDLE**: `o_uart_tx`=1. On acceptance, go to START.
  - **START**: line = 0 for one baud.
  - **DATA**: 8 bauds, LSB first. The shift register shifts right once per baud.
  - **STOP**: line = 1 for one baud, then go to IDLE.
  - If a new acceptance occurs in the final cycle of STOP, go directly to START with no idle gap.
- Baud counter:
  - 24-bit down-counter, loaded with `CLOCKS_PER_BAUD-1` at each bit start.
  - A bit ends when the counter reads 0.
  - A 4-bit bit index counts the 10 bits of the frame.
- `o_uart_tx` is driven from a register and is glitch-free.
- `i_stb` while busy is ignored. The upstream holds `i_stb` and `i_data` until acceptance.
- `i_data` changes while busy have no effect on the frame in flight.

## Timing
- Reset values (asynchronous, while `i_rst_n`=0):
  - state = IDLE
  - `o_uart_tx` = 1
  - `o_busy` = 0
  - counter = 0
  - bit index = 0
  - shift register = 8'hFF
- Accept at cycle T:
  - `o_uart_tx` = 0 from T+1 through T+CLOCKS_PER_BAUD.
  - Data bit k occupies cycles T+1+(k+1)·CPB through T+(k+2)·CPB.
  - Stop bit occupies T+1+9·CPB through T+10·CPB.
- `o_busy`:
  - Registered.
  - 1 from T+1 through T+10·CPB-1.
  - 0 at cycle T+10·CPB, which is the last stop cycle.
  - An acceptance at T+10·CPB puts the next start bit at T+10·CPB+1. The frame period is therefore exactly 10·CPB cycles back-to-back.
- No combinational path from `i_stb` to `o_busy`.
- Reset mid-frame: line returns to 1 immediately (asynchronously). The partial frame is abandoned and not resumed.

## Configuration
- **`WBUTXUART_CTS_EN` defined**:
  - `i_cts_n` is passed through a 2-flop synchroniser.
  - `o_busy` is forced to 1 whenever the synchronised `i_cts_n` = 1, so no new frame starts.
  - A frame already in progress always completes.
  - Reset value of both synchroniser flops is 1 (not clear).
- **`WBUTXUART_CTS_EN` undefined**:
  - `i_cts_n` is ignored and no synchroniser is built.
  - Behaviour is exactly as in Operation/Timing.

## Test plan
- **Single byte**: CPB=4, reset, accept 8'hA5 at T.
  - Line samples at T+2+4n for n=0..9 read 0,1,0,1,0,0,1,0,1,1.
  - `o_busy` is low again at T+40.
- **Back-to-back**: CPB=4, `i_stb` held high with 8'h00 then 8'hFF.
  - Second start bit begins at T+41, with no idle cycle.
  - Exactly 2 acceptances in 80 cycles.
- **Hold while busy**: `i_stb` asserted at T+5 with 8'h3C, while busy.
  - No acceptance until T+40.
  - 8'h3C is transmitted intact.
  - The first frame is unaffected by `i_data` changes.
- **Reset mid-frame**: deassert `i_rst_n` during data bit 3.
  - `o_uart_tx`=1 and `o_busy`=0 within the reset cycle, asynchronously.
  - After release, 8'h5A transmits correctly.
- **Minimum divider**: CPB=2, 8'h81.
  - Frame lasts exactly 20 cycles.
  - Bit pattern is 0,1,0,0,0,0,0,0,1,1.
- **CTS** (`WBUTXUART_CTS_EN` defined):
  - `i_cts_n`=1 with `i_stb` high: no start bit for 100 cycles.
  - Drop `i_cts_n` at cycle C: acceptance at C+2, start bit at C+3.
  - Raise `i_cts_n` mid-frame: the frame still completes.
